fsk_rx_byte_buffer: RTL

- Downstream consumer of the FSK link's decoded 4-bit output (`outputData` with its `wr` strobe).
- Detects each new-nibble event, pairs nibbles into bytes (first nibble = high nibble) and buffers bytes in a small synchronous FIFO.
- Presents buffered bytes on a valid/ready interface for the host side.
- Flags overflow and abandoned half-bytes.

---
 rtl/fsk_rx_pkg.sv | 12 +
 rtl/fsk_byte_fifo.sv | 70 +++++++
 rtl/fsk_rx_byte_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/fsk_rx_pkg.sv
// Shared types and constants for the FSK receive byte buffer.
package fsk_rx_pkg;
  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic {IDLE, HALF} rx_state_e;

  // Width of a counter that must reach cyc-1.
  function automatic int tmr_w(input int cyc);
    return (cyc > 2) ? $clog2(cyc) : 1;
  endfunction
endpackage

// File: rtl/fsk_byte_fifo.sv
// Synchronous DEPTH x BYTE_W FIFO with a registered head output that
// tracks the next head in the same cycle as push/pop.
module fsk_byte_fifo
  import fsk_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [BYTE_W-1:0]       din_i,
  output logic [BYTE_W-1:0]       dout_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, head_idx;
  logic [AW:0]       level_q, level_d;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic              push_acc, pop_acc;

  assign empty_o  = (level_q == '0);
  assign full_o   = (level_q == LVL_FULL);
  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);
  assign head_idx = pop_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_comb begin
    level_d = level_q;
    unique case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // A lone entry that was just written is not in mem_q yet; bypass it.
    dout_d = dout_q;
    if (level_d != '0) begin
      if (push_acc && level_d == LVL_ONE) dout_d = din_i;
      else                                dout_d = mem_q[head_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      dout_q  <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign level_o = level_q;
endmodule

// File: rtl/fsk_rx_byte_buffer.sv
// Pairs decoded FSK nibbles into bytes and buffers them for a valid/ready host.
// Optional FSK_RX_PAIR_TIMEOUT_EN: discard a lone high nibble after TIMEOUT_CYC.
module fsk_rx_byte_buffer
  import fsk_rx_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NIB_W-1:0]        nib_data,
  input  logic                    nib_wr,
  output logic [BYTE_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    partial_drop
);
  rx_state_e        state_q, state_d;
  logic [NIB_W-1:0] hi_q, hi_d;
  logic             nib_wr_q, stb, tmo;
  logic             push, pop, full, empty, overflow_q;

  // nib_wr is a level; only its rising edge is a new nibble.
  assign stb = nib_wr & ~nib_wr_q;
  assign pop = out_valid && out_ready;

`ifdef FSK_RX_PAIR_TIMEOUT_EN
  localparam int TW = tmr_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmr_q;
  logic          pd_q;

  assign tmo = (tmr_q == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
      pd_q  <= 1'b0;
    end else begin
      tmr_q <= (state_q == HALF) ? tmr_q + 1'b1 : '0;
      pd_q  <= (state_q == HALF) && !stb && tmo;
    end
  end
  assign partial_drop = pd_q;
`else
  assign tmo          = 1'b0;
  assign partial_drop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (stb) begin
        hi_d    = nib_data;
        state_d = HALF;
      end
      HALF: begin
        // A nibble arriving on the expiry cycle still completes the byte.
        if (stb) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      nib_wr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      nib_wr_q <= nib_wr;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  fsk_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({hi_q, nib_data}),
    .dout_o  (out_data),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid = !empty;
  assign overflow  = overflow_q;
endmodule
